// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and data ports of the core, data first with a bounded burst.
// Latency: grant -> strobe next cycle -> ready pulse after m_ack (3 cycles min); backpressure: core_stall while a request is unanswered.
module mem_port_arbiter #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              bus_err,
    output logic              core_stall,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_re,
    output logic              m_we,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack
);
    localparam int RUN_W = $clog2(MAX_D_BURST + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q;
    logic              own_data_q;
    logic              wr_q;
    logic [RUN_W-1:0]  d_run_q;
    logic [RUN_W-1:0]  d_run_d;
    logic [TMO_W-1:0]  tmo_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic              m_re_q;
    logic              m_we_q;
    logic              if_ready_q;
    logic              d_ready_q;
    logic              bus_err_q;

    logic d_req;
    logic gnt_d;
    logic gnt_i;

    // Data keeps priority until it has won MAX_D_BURST grants in a row over a waiting fetch.
    always_comb begin
        d_req   = d_rd | d_wr;
        gnt_d   = d_req && ((d_run_q < RUN_W'(MAX_D_BURST)) || !if_req);
        gnt_i   = !gnt_d && if_req;
        d_run_d = d_run_q;
        if (gnt_d) begin
            if (!if_req) begin
                d_run_d = '0;
            end else if (d_run_q != RUN_W'(MAX_D_BURST)) begin
                d_run_d = d_run_q + RUN_W'(1);
            end
        end else if (gnt_i) begin
            d_run_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            own_data_q <= 1'b0;
            wr_q       <= 1'b0;
            d_run_q    <= '0;
            tmo_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_re_q     <= 1'b0;
            m_we_q     <= 1'b0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_d) begin
                        own_data_q <= 1'b1;
                        wr_q       <= d_wr;
                        m_addr_q   <= d_addr;
                        m_wdata_q  <= d_wdata;
                        m_re_q     <= ~d_wr;
                        m_we_q     <= d_wr;
                        d_run_q    <= d_run_d;
                        state_q    <= ACCESS;
                    end else if (gnt_i) begin
                        own_data_q <= 1'b0;
                        wr_q       <= 1'b0;
                        m_addr_q   <= if_addr;
                        m_re_q     <= 1'b1;
                        m_we_q     <= 1'b0;
                        d_run_q    <= d_run_d;
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (m_ack) begin
                        if (!wr_q) begin
                            if (own_data_q) begin
                                d_rdata_q <= m_rdata;
                            end else begin
                                if_rdata_q <= m_rdata;
                            end
                        end
                        m_re_q     <= 1'b0;
                        m_we_q     <= 1'b0;
                        bus_err_q  <= 1'b0;
                        d_ready_q  <= own_data_q;
                        if_ready_q <= ~own_data_q;
                        state_q    <= RESP;
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        // Abort: the rdata register keeps its old contents.
                        tmo_q      <= tmo_q + TMO_W'(1);
                        m_re_q     <= 1'b0;
                        m_we_q     <= 1'b0;
                        bus_err_q  <= 1'b1;
                        d_ready_q  <= own_data_q;
                        if_ready_q <= ~own_data_q;
                        state_q    <= RESP;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                RESP: begin
                    if_ready_q <= 1'b0;
                    d_ready_q  <= 1'b0;
                    bus_err_q  <= 1'b0;
                    tmo_q      <= '0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata   = if_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign m_addr     = m_addr_q;
    assign m_wdata    = m_wdata_q;
    assign m_re       = m_re_q;
    assign m_we       = m_we_q;
    assign if_ready   = if_ready_q;
    assign d_ready    = d_ready_q;
    assign bus_err    = bus_err_q;
    assign core_stall = (if_req & ~if_ready_q) | ((d_rd | d_wr) & ~d_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference model plus per-cycle compare and literal checks.
module tb_mem_port_arbiter;
    localparam int MAXB = 2;
    localparam int TMO  = 15;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ready;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ready;
    logic        bus_err;
    logic        core_stall;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic        m_re;
    logic        m_we;
    logic [15:0] m_rdata;
    logic        m_ack;

    mem_port_arbiter #(
        .DATA_W(16), .ADDR_W(16), .MAX_D_BURST(MAXB), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .bus_err(bus_err), .core_stall(core_stall),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_re(m_re), .m_we(m_we),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    string order = "";
    bit    cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks after wait_n strobe cycles, or always when tied.
    bit          mem_tied = 1'b0;
    int          wait_n   = 0;
    int          wcnt     = 0;
    logic [15:0] rd_xor   = 16'h0000;

    always @(posedge clk) begin
        #1;
        m_rdata = m_addr ^ rd_xor;
        if (mem_tied) begin
            m_ack = 1'b1;
            wcnt  = 0;
        end else if (m_re | m_we) begin
            m_ack = (wcnt >= wait_n);
            wcnt++;
        end else begin
            m_ack = 1'b0;
            wcnt  = 0;
        end
    end

    // Reference model: one outstanding transaction, described by owner/op/wait count.
    bit          mb_act, mb_resp, mb_data, mb_wr;
    int          mb_wait, m_run;
    logic [15:0] e_addr, e_wdata, e_if_rdata, e_d_rdata;
    logic        e_re, e_we, e_if_rdy, e_d_rdy, e_err;

    task automatic model_finish(input bit err);
        mb_act  = 1'b0;
        mb_resp = 1'b1;
        e_re    = 1'b0;
        e_we    = 1'b0;
        e_err   = err;
        if (mb_data) e_d_rdy = 1'b1;
        else         e_if_rdy = 1'b1;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mb_act = 0; mb_resp = 0; mb_data = 0; mb_wr = 0; mb_wait = 0; m_run = 0;
            e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
            e_re = 0; e_we = 0; e_if_rdy = 0; e_d_rdy = 0; e_err = 0;
        end else if (mb_resp) begin
            mb_resp = 0; e_if_rdy = 0; e_d_rdy = 0; e_err = 0;
        end else if (mb_act) begin
            if (m_ack) begin
                if (!mb_wr) begin
                    if (mb_data) e_d_rdata = m_rdata;
                    else         e_if_rdata = m_rdata;
                end
                model_finish(1'b0);
            end else begin
                mb_wait++;
                if (mb_wait == TMO) model_finish(1'b1);
            end
        end else if ((d_rd | d_wr) && (m_run < MAXB || !if_req)) begin
            mb_act = 1; mb_data = 1; mb_wr = d_wr; mb_wait = 0;
            e_addr = d_addr; e_wdata = d_wdata; e_we = d_wr; e_re = !d_wr;
            m_run = if_req ? ((m_run + 1 > MAXB) ? MAXB : m_run + 1) : 0;
        end else if (if_req) begin
            mb_act = 1; mb_data = 0; mb_wr = 0; mb_wait = 0;
            e_addr = if_addr; e_re = 1; e_we = 0;
            m_run = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_re", m_re, e_re);
            chk("m_we", m_we, e_we);
            chk("m_addr", m_addr, e_addr);
            chk("m_wdata", m_wdata, e_wdata);
            chk("if_ready", if_ready, e_if_rdy);
            chk("d_ready", d_ready, e_d_rdy);
            chk("bus_err", bus_err, e_err);
            chk("if_rdata", if_rdata, e_if_rdata);
            chk("d_rdata", d_rdata, e_d_rdata);
            chk("core_stall", core_stall, (if_req & ~e_if_rdy) | ((d_rd | d_wr) & ~e_d_rdy));
        end
        if (if_ready) order = {order, "I"};
        if (d_ready)  order = {order, "D"};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input bit dside, input int lim, output int c);
        bit got;
        got = 1'b0;
        c   = 0;
        while (!got && c < lim) begin
            @(negedge clk);
            c++;
            got = dside ? d_ready : if_ready;
        end
        if (dside) chk("d_ready_seen", got, 1);
        else       chk("if_ready_seen", got, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c, we_cnt, re_cnt;
        bit got;
        rst = 1'b1; if_req = 0; if_addr = '0; d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        m_ack = 0; m_rdata = '0;
        #2 rst = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (2) step();
        chk("rst_m_re", m_re, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_m_addr", m_addr, 16'h0000);
        chk("rst_d_rdata", d_rdata, 16'h0000);
        rst = 1'b1;
        step();

        // Zero-wait fetch with m_ack tied high.
        mem_tied = 1; rd_xor = 16'h1230;
        if_req = 1; if_addr = 16'h0004;
        @(negedge clk);
        chk("f_stall_pre", core_stall, 1);
        chk("f_idle_m_re", m_re, 0);
        @(negedge clk);
        chk("f_m_re", m_re, 1);
        chk("f_m_addr", m_addr, 16'h0004);
        @(negedge clk);
        chk("f_if_ready", if_ready, 1);
        chk("f_if_rdata", if_rdata, 16'h1234);
        chk("f_bus_err", bus_err, 0);
        chk("f_stall_rdy", core_stall, 0);
        step();
        if_req = 0; mem_tied = 0;
        @(negedge clk);
        chk("f_if_ready_pulse", if_ready, 0);
        step();

        // Reset in the middle of an access, then a normal fetch.
        wait_n = 1000;
        d_rd = 1; d_addr = 16'h0020;
        @(negedge clk);
        @(negedge clk);
        chk("r_m_re_before", m_re, 1);
        #1 rst = 1'b0;
        #1;
        chk("r_m_re", m_re, 0);
        chk("r_m_addr", m_addr, 16'h0000);
        chk("r_if_rdata", if_rdata, 16'h0000);
        chk("r_d_ready", d_ready, 0);
        step();
        d_rd = 0;
        step();
        rst = 1'b1;
        wait_n = 0;
        step();
        if_req = 1; if_addr = 16'h0008;
        wait_rdy(0, 10, c);
        chk("r_recover_latency", c, 3);
        chk("r_recover_rdata", if_rdata, 16'h1238);
        step();
        if_req = 0;
        step();

        // Contention with MAX_D_BURST=2: three reads against a held fetch.
        order = "";
        fork
            begin
                int fc;
                if_req = 1; if_addr = 16'h0100;
                wait_rdy(0, 30, fc);
                chk("c_if_rdata", if_rdata, 16'h1330);
                step();
                if_req = 0;
            end
            begin
                int dc;
                for (int k = 0; k < 3; k++) begin
                    d_rd = 1; d_addr = 16'h0200 + 16'(k);
                    wait_rdy(1, 30, dc);
                    chk("c_d_rdata", d_rdata, 16'h1030 + 16'(k));
                    step();
                end
                d_rd = 0;
            end
        join
        chk("c_grant_order", (order == "DDID") ? 1 : 0, 1);
        step();

        // Write with three wait states.
        wait_n = 3;
        d_wr = 1; d_addr = 16'h0010; d_wdata = 16'hBEEF;
        we_cnt = 0; re_cnt = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (m_we) begin
                we_cnt++;
                chk("w_m_addr", m_addr, 16'h0010);
                chk("w_m_wdata", m_wdata, 16'hBEEF);
            end
            if (m_re) re_cnt++;
            if (d_ready) begin
                got = 1;
                chk("w_bus_err", bus_err, 0);
            end
        end
        chk("w_ready_seen", got, 1);
        chk("w_we_cycles", we_cnt, 4);
        chk("w_re_cycles", re_cnt, 0);
        chk("w_d_rdata_kept", d_rdata, 16'h1032);
        step();
        d_wr = 0;
        @(negedge clk);
        chk("w_d_ready_pulse", d_ready, 0);
        step();

        // Read that never gets m_ack: abort after TIMEOUT access cycles.
        wait_n = 1000;
        d_rd = 1; d_addr = 16'h0030;
        re_cnt = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (m_re) re_cnt++;
            if (d_ready) begin
                got = 1;
                chk("t_bus_err", bus_err, 1);
            end
        end
        chk("t_ready_seen", got, 1);
        chk("t_re_cycles", re_cnt, 15);
        chk("t_d_rdata_kept", d_rdata, 16'h1032);
        step();
        d_rd = 0;
        @(negedge clk);
        chk("t_bus_err_clear", bus_err, 0);
        step();

        // Simultaneous read and write: one write access only.
        wait_n = 1;
        d_rd = 1; d_wr = 1; d_addr = 16'h0040; d_wdata = 16'h5A5A;
        we_cnt = 0; re_cnt = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (m_we) we_cnt++;
            if (m_re) re_cnt++;
            if (d_ready) begin
                got = 1;
                chk("b_stall_low", core_stall, 0);
            end else begin
                chk("b_stall_high", core_stall, 1);
            end
        end
        chk("b_ready_seen", got, 1);
        chk("b_we_cycles", we_cnt, 2);
        chk("b_re_cycles", re_cnt, 0);
        chk("b_d_rdata_kept", d_rdata, 16'h1032);
        step();
        d_rd = 0; d_wr = 0;
        re_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (m_re | m_we) re_cnt++;
        end
        chk("b_no_extra_access", re_cnt, 0);

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
